// File: rtl/hazard_mdu_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: Tuse/Tnew stall detection,
// D/E forwarding selects, multiply/divide busy sequencing and a stall-cycle counter.

module hazard_opnd (
    input  logic [4:0] a_d,
    input  logic [1:0] tuse_d,
    input  logic [4:0] a_e,
    input  logic [4:0] a3_e,
    input  logic       rfen_e,
    input  logic [2:0] tnew_e,
    input  logic [4:0] a3_m,
    input  logic       rfen_m,
    input  logic [2:0] tnew_m,
    input  logic [4:0] a3_w,
    input  logic       rfen_w,
    output logic       stall,
    output logic [1:0] fwd_d,
    output logic [1:0] fwd_e
);
    logic hit_e, hit_m, hit_w, hit_m_e, hit_w_e;

    always_comb begin
        hit_e   = rfen_e && (a3_e == a_d) && (a_d != 5'd0);
        hit_m   = rfen_m && (a3_m == a_d) && (a_d != 5'd0);
        hit_w   = rfen_w && (a3_w == a_d) && (a_d != 5'd0);
        hit_m_e = rfen_m && (a3_m == a_e) && (a_e != 5'd0);
        hit_w_e = rfen_w && (a3_w == a_e) && (a_e != 5'd0);

        // Tuse of 3 marks an unused operand, so it can never stall.
        stall = (tuse_d != 2'd3) &&
                ((hit_e && (tnew_e > {1'b0, tuse_d})) ||
                 (hit_m && (tnew_m > {1'b0, tuse_d})));

        // The youngest producer wins; if it is not ready the stall covers it.
        fwd_d = 2'd0;
        if (hit_e)      fwd_d = (tnew_e == 3'd0) ? 2'd3 : 2'd0;
        else if (hit_m) fwd_d = (tnew_m == 3'd0) ? 2'd1 : 2'd0;
        else if (hit_w) fwd_d = 2'd2;

        fwd_e = 2'd0;
        if (hit_m_e && (tnew_m == 3'd0)) fwd_e = 2'd1;
        else if (hit_w_e)                fwd_e = 2'd2;
    end
endmodule

module hazard_mdu_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1D,
    input  logic [4:0]  A2D,
    input  logic [1:0]  TuseRsD,
    input  logic [1:0]  TuseRtD,
    input  logic [4:0]  A1E,
    input  logic [4:0]  A2E,
    input  logic [4:0]  A3E,
    input  logic        RFenE,
    input  logic [2:0]  TnewE,
    input  logic [4:0]  A3M,
    input  logic        RFenM,
    input  logic [2:0]  TnewM,
    input  logic [4:0]  A3W,
    input  logic        RFenW,
    input  logic [1:0]  mdStartE,
    input  logic        mdUseD,
    output logic        stallF,
    output logic        stallD,
    output logic        clrE,
    output logic [1:0]  FwdRsD,
    output logic [1:0]  FwdRtD,
    output logic [1:0]  FwdRsE,
    output logic [1:0]  FwdRtE,
    output logic        mdBusy,
    output logic        mdDone,
    output logic [31:0] stallCnt
);
    localparam int NOPS = 2;
    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    logic [NOPS-1:0][4:0] a_d, a_e;
    logic [NOPS-1:0][1:0] tuse_d, fwd_d, fwd_e;
    logic [NOPS-1:0]      stall_op;

    assign a_d    = {A2D, A1D};
    assign a_e    = {A2E, A1E};
    assign tuse_d = {TuseRtD, TuseRsD};

    // Index 0 is rs, index 1 is rt.
    for (genvar i = 0; i < NOPS; i++) begin : g_op
        hazard_opnd u_op (
            .a_d    (a_d[i]),
            .tuse_d (tuse_d[i]),
            .a_e    (a_e[i]),
            .a3_e   (A3E),
            .rfen_e (RFenE),
            .tnew_e (TnewE),
            .a3_m   (A3M),
            .rfen_m (RFenM),
            .tnew_m (TnewM),
            .a3_w   (A3W),
            .rfen_w (RFenW),
            .stall  (stall_op[i]),
            .fwd_d  (fwd_d[i]),
            .fwd_e  (fwd_e[i])
        );
    end

    md_state_e   md_st;
    logic [3:0]  cnt_d, cnt_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic        md_start, stall;

    always_comb begin
        md_st    = (cnt_q == 4'd0) ? MD_IDLE : MD_BUSY;
        md_start = (mdStartE == 2'b01) || (mdStartE == 2'b10);
        // A start still in E counts as busy so a dependent D instruction waits.
        stall    = (|stall_op) || (mdUseD && ((md_st == MD_BUSY) || md_start));

        cnt_d = cnt_q;
        case (md_st)
            MD_IDLE: begin
                if (mdStartE == 2'b01)      cnt_d = MULT_LD;
                else if (mdStartE == 2'b10) cnt_d = DIV_LD;
            end
            MD_BUSY: cnt_d = cnt_q - 4'd1;
            default: cnt_d = 4'd0;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= 4'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallF   = stall;
    assign stallD   = stall;
    assign clrE     = stall;
    assign FwdRsD   = fwd_d[0];
    assign FwdRtD   = fwd_d[1];
    assign FwdRsE   = fwd_e[0];
    assign FwdRtE   = fwd_e[1];
    assign mdBusy   = (cnt_q != 4'd0);
    assign mdDone   = (cnt_q == 4'd1);
    assign stallCnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_mdu_ctrl.sv
// Bench for hazard_mdu_ctrl: constant vector table, MDU/reset/saturation sequences,
// and random stimulus checked against a rule-level model of the controller.

module tb_hazard_mdu_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0, reset = 1'b1;
    logic [4:0]  A1D, A2D, A1E, A2E, A3E, A3M, A3W;
    logic [1:0]  TuseRsD, TuseRtD, mdStartE;
    logic        RFenE, RFenM, RFenW, mdUseD;
    logic [2:0]  TnewE, TnewM;
    logic        stallF, stallD, clrE, mdBusy, mdDone;
    logic [1:0]  FwdRsD, FwdRtD, FwdRsE, FwdRtE;
    logic [31:0] stallCnt;

    hazard_mdu_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
        .clk(clk), .reset(reset), .A1D(A1D), .A2D(A2D), .TuseRsD(TuseRsD), .TuseRtD(TuseRtD),
        .A1E(A1E), .A2E(A2E), .A3E(A3E), .RFenE(RFenE), .TnewE(TnewE),
        .A3M(A3M), .RFenM(RFenM), .TnewM(TnewM), .A3W(A3W), .RFenW(RFenW),
        .mdStartE(mdStartE), .mdUseD(mdUseD), .stallF(stallF), .stallD(stallD), .clrE(clrE),
        .FwdRsD(FwdRsD), .FwdRtD(FwdRtD), .FwdRsE(FwdRsE), .FwdRtE(FwdRtE),
        .mdBusy(mdBusy), .mdDone(mdDone), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a1d, a2d, a1e, a2e, a3e, a3m, a3w;
        logic [1:0] trs, trt, mds;
        logic       rfe, rfm, rfw, mdu;
        logic [2:0] tne, tnm;
    } in_t;

    typedef struct {
        in_t        i;
        logic       stall;
        logic [1:0] frsd, frtd, frse, frte;
    } vec_t;

    int          checks = 0, errors = 0;
    int          m_cnt  = 0;          // busy cycles left in the model
    logic [31:0] m_scnt = 32'd0;
    vec_t        tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t idle_in();
        in_t v;
        v = '{a1d:0, a2d:0, a1e:0, a2e:0, a3e:0, a3m:0, a3w:0, trs:3, trt:3, mds:0,
              rfe:0, rfm:0, rfw:0, mdu:0, tne:0, tnm:0};
        return v;
    endfunction

    // A stage "produces" reg a if it writes it, and $0 is never produced.
    function automatic bit produces(input logic [4:0] a3, input logic en, input logic [4:0] a);
        return en && a != 0 && a3 == a;
    endfunction

    function automatic bit m_data_stall(input in_t v, input logic [4:0] a, input logic [1:0] tuse);
        if (tuse == 3) return 0;
        if (produces(v.a3e, v.rfe, a) && int'(v.tne) > int'(tuse)) return 1;
        if (produces(v.a3m, v.rfm, a) && int'(v.tnm) > int'(tuse)) return 1;
        return 0;
    endfunction

    function automatic bit m_stall(input in_t v);
        bit md;
        md = v.mdu && (m_cnt > 0 || v.mds == 2'b01 || v.mds == 2'b10);
        return md || m_data_stall(v, v.a1d, v.trs) || m_data_stall(v, v.a2d, v.trt);
    endfunction

    function automatic logic [1:0] m_fwd_d(input in_t v, input logic [4:0] a);
        logic [4:0] a3s[3];
        logic       ens[3];
        int         tn[3];
        logic [1:0] code[3];
        a3s = '{v.a3e, v.a3m, v.a3w}; ens = '{v.rfe, v.rfm, v.rfw};
        tn  = '{int'(v.tne), int'(v.tnm), 0}; code = '{2'd3, 2'd1, 2'd2};
        for (int s = 0; s < 3; s++)
            if (produces(a3s[s], ens[s], a)) return (tn[s] == 0) ? code[s] : 2'd0;
        return 2'd0;
    endfunction

    function automatic logic [1:0] m_fwd_e(input in_t v, input logic [4:0] a);
        if (produces(v.a3m, v.rfm, a) && v.tnm == 0) return 2'd1;
        if (produces(v.a3w, v.rfw, a)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic apply(input in_t v);
        A1D = v.a1d; A2D = v.a2d; TuseRsD = v.trs; TuseRtD = v.trt;
        A1E = v.a1e; A2E = v.a2e; A3E = v.a3e; RFenE = v.rfe; TnewE = v.tne;
        A3M = v.a3m; RFenM = v.rfm; TnewM = v.tnm; A3W = v.a3w; RFenW = v.rfw;
        mdStartE = v.mds; mdUseD = v.mdu;
    endtask

    // Drive one cycle's inputs, check everything against the model, then advance the model.
    task automatic step(input in_t v);
        bit s;
        @(negedge clk);
        apply(v);
        #1;
        s = m_stall(v);
        chk("stallF", stallF, s); chk("stallD", stallD, s); chk("clrE", clrE, s);
        chk("FwdRsD", FwdRsD, m_fwd_d(v, v.a1d)); chk("FwdRtD", FwdRtD, m_fwd_d(v, v.a2d));
        chk("FwdRsE", FwdRsE, m_fwd_e(v, v.a1e)); chk("FwdRtE", FwdRtE, m_fwd_e(v, v.a2e));
        chk("mdBusy", mdBusy, m_cnt > 0); chk("mdDone", mdDone, m_cnt == 1);
        chk("stallCnt", stallCnt, m_scnt);
        if (s && m_scnt != 32'hFFFF_FFFF) m_scnt++;
        if (m_cnt > 0) m_cnt--;
        else if (v.mds == 2'b01) m_cnt = MULT_N;
        else if (v.mds == 2'b10) m_cnt = DIV_N;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m_cnt = 0; m_scnt = 32'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic in_t rand_in();
        in_t v;
        v.a1d = 5'($urandom_range(0, 3)); v.a2d = 5'($urandom_range(0, 3));
        v.a1e = 5'($urandom_range(0, 3)); v.a2e = 5'($urandom_range(0, 3));
        v.a3e = 5'($urandom_range(0, 3)); v.a3m = 5'($urandom_range(0, 3));
        v.a3w = 5'($urandom_range(0, 3));
        v.trs = 2'($urandom_range(0, 3)); v.trt = 2'($urandom_range(0, 3));
        v.rfe = 1'($urandom_range(0, 1)); v.rfm = 1'($urandom_range(0, 1));
        v.rfw = 1'($urandom_range(0, 1)); v.mdu = 1'($urandom_range(0, 1));
        v.tne = 3'($urandom_range(0, 2)); v.tnm = 3'($urandom_range(0, 1));
        v.mds = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        return v;
    endfunction

    initial begin
        in_t v;
        int  busy_seen;

        // Vector table: constant expectations for the combinational paths.
        for (int n = 0; n < 12; n++) begin
            tbl[n].i = idle_in();
            tbl[n].stall = 0; tbl[n].frsd = 0; tbl[n].frtd = 0; tbl[n].frse = 0; tbl[n].frte = 0;
        end
        // load in E, rs needed in E
        tbl[0].i.a3e = 5; tbl[0].i.rfe = 1; tbl[0].i.tne = 2; tbl[0].i.a1d = 5; tbl[0].i.trs = 1;
        tbl[0].stall = 1;
        // load now in M, consumer needs it in D
        tbl[1].i.a3m = 5; tbl[1].i.rfm = 1; tbl[1].i.tnm = 1; tbl[1].i.a1d = 5; tbl[1].i.trs = 0;
        tbl[1].stall = 1;
        // load in M, consumer needs it in E: Tnew == Tuse is not a stall
        tbl[2].i.a3m = 5; tbl[2].i.rfm = 1; tbl[2].i.tnm = 1; tbl[2].i.a1d = 5; tbl[2].i.trs = 1;
        // ready in M
        tbl[3].i.a3m = 5; tbl[3].i.rfm = 1; tbl[3].i.tnm = 0; tbl[3].i.a1d = 5; tbl[3].i.trs = 0;
        tbl[3].frsd = 1;
        // all three stages write $7: E wins
        tbl[4].i.a3e = 7; tbl[4].i.a3m = 7; tbl[4].i.a3w = 7; tbl[4].i.rfe = 1; tbl[4].i.rfm = 1;
        tbl[4].i.rfw = 1; tbl[4].i.a2d = 7; tbl[4].i.trt = 0;
        tbl[4].frtd = 3;
        tbl[5] = tbl[4]; tbl[5].i.rfe = 0; tbl[5].frtd = 1;
        // $0 never hazards
        tbl[6].i.rfe = 1; tbl[6].i.tne = 2; tbl[6].i.trs = 0;
        // unused operand never stalls
        tbl[7].i.a3e = 5; tbl[7].i.rfe = 1; tbl[7].i.tne = 2; tbl[7].i.a1d = 5; tbl[7].i.trs = 3;
        // E-stage forwarding, M ready
        tbl[8].i.a1e = 9; tbl[8].i.a2e = 9; tbl[8].i.a3m = 9; tbl[8].i.rfm = 1; tbl[8].i.a3w = 9;
        tbl[8].i.rfw = 1;
        tbl[8].frse = 1; tbl[8].frte = 1;
        tbl[9] = tbl[8]; tbl[9].i.tnm = 1; tbl[9].frse = 2; tbl[9].frte = 2;
        // W only, D-stage select 2
        tbl[10].i.a3w = 3; tbl[10].i.rfw = 1; tbl[10].i.a2d = 3; tbl[10].i.trt = 0;
        tbl[10].frtd = 2;
        // MDU user in D with idle unit
        tbl[11].i.mdu = 1;

        apply(idle_in());
        TuseRsD = 0; TuseRtD = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst mdBusy", mdBusy, 0); chk("rst mdDone", mdDone, 0);
        chk("rst stallCnt", stallCnt, 0); chk("rst stall", stallF, 0);
        chk("rst FwdRsD", FwdRsD, 0); chk("rst FwdRsE", FwdRsE, 0);
        reset = 1'b0;

        for (int n = 0; n < 12; n++) begin
            step(tbl[n].i);
            chk($sformatf("tbl%0d stall", n), stallD, tbl[n].stall);
            chk($sformatf("tbl%0d FwdRsD", n), FwdRsD, tbl[n].frsd);
            chk($sformatf("tbl%0d FwdRtD", n), FwdRtD, tbl[n].frtd);
            chk($sformatf("tbl%0d FwdRsE", n), FwdRsE, tbl[n].frse);
            chk($sformatf("tbl%0d FwdRtE", n), FwdRtE, tbl[n].frte);
        end

        // Divide with a dependent MDU user held in D.
        do_reset();
        v = idle_in(); v.mdu = 1; v.mds = 2'b10;
        step(v);
        chk("div start stall", stallD, 1);
        v.mds = 2'b00;
        for (int k = 0; k < DIV_N; k++) begin
            step(v);
            chk("div busy", mdBusy, 1);
            chk("div done", mdDone, k == DIV_N - 1);
        end
        step(v);
        chk("div release", stallD, 0);
        chk("div stallCnt", stallCnt, 11);

        // Asynchronous reset in the middle of a multiply.
        do_reset();
        v = idle_in(); v.mdu = 1; v.mds = 2'b01;
        step(v);
        v = idle_in();
        step(v); step(v);
        chk("mul busy before rst", mdBusy, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async rst mdBusy", mdBusy, 0);
        chk("async rst stallCnt", stallCnt, 0);
        m_cnt = 0; m_scnt = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        v.mds = 2'b01;
        step(v);
        v.mds = 2'b00;
        busy_seen = 0;
        for (int k = 0; k < MULT_N + 2; k++) begin
            step(v);
            if (mdBusy) busy_seen++;
        end
        chk("mul busy cycles", busy_seen, MULT_N);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) step(rand_in());

        // Counter saturation from a preloaded value.
        do_reset();
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1 release dut.stall_cnt_q;
        m_scnt = 32'hFFFF_FFFD;
        for (int k = 0; k < 4; k++) step(tbl[0].i);
        chk("sat stallCnt", stallCnt, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
